// File: rtl/mux_sched_if.sv
// mux_sched_if: request/grant and control-channel bundle between the
// clocked requesters, the scheduler and the asynchronous mux.
//   req0/req1     level requests, held until the matching done pulse
//   gnt0/gnt1     current owner of the mux
//   done0/done1   one-cycle completion pulses
//   ctl_a/ctl_b   registered control rails into the self-timed mux
//   actl_i        asynchronous control acknowledge from the mux
//   cnt0/cnt1     wrapping completion counters
//   busy/err      scheduler activity and sticky watchdog flag
// master = requesters + mux side, slave = the scheduler.
interface mux_sched_if #(
    parameter int CNTW = 8
);
    logic            req0, req1;
    logic            gnt0, gnt1;
    logic            done0, done1;
    logic            ctl_a, ctl_b;
    logic            actl_i;
    logic [CNTW-1:0] cnt0, cnt1;
    logic            busy, err;

    modport master (
        output req0, req1, actl_i,
        input  gnt0, gnt1, done0, done1, ctl_a, ctl_b, cnt0, cnt1, busy, err
    );

    modport slave (
        input  req0, req1, actl_i,
        output gnt0, gnt1, done0, done1, ctl_a, ctl_b, cnt0, cnt1, busy, err
    );
endinterface

// File: rtl/mux_sched.sv
// mux_sched: arbitrates two clocked requesters for a two-input asynchronous
// handshake mux and issues one four-phase return-to-zero control token
// (ctl_a or ctl_b) per grant against the mux's control acknowledge.
// Ports:
//   clk, rst  clock, synchronous active-high reset
//   bus       mux_sched_if.slave (requests, grants, done pulses, control
//             rails, async acknowledge, counters, busy, err)
// Parameters: SYNC (2..4) ack synchroniser depth, PRIO (0 round-robin,
// 1 req0 always wins), TMO watchdog cycles (0 = off), CNTW counter width.
module mux_sched #(
    parameter int SYNC = 2,
    parameter int PRIO = 0,
    parameter int TMO  = 1024,
    parameter int CNTW = 8
) (
    input  logic       clk,
    input  logic       rst,
    mux_sched_if.slave bus
);
    // The FSM register that consumes ack_s acts as the final synchroniser
    // stage, so only SYNC-1 dedicated flops sit in front of it. This gives
    // the SYNC-edge latency from ack to FSM reaction.
    localparam int          SW    = SYNC - 1;
    localparam logic [15:0] TMO_L = 16'(TMO);

    typedef enum logic [1:0] {IDLE, SET, CLR, DONE} state_t;

    state_t          state;
    logic [SW-1:0]   sync_q;
    logic            ack_s;
    logic            sel1;
    logic            last_q;
    logic [15:0]     wd_q;
    logic [15:0]     wd_inc;
    logic            wd_hit;
    logic            gnt0_q, gnt1_q, done0_q, done1_q;
    logic            ctl_a_q, ctl_b_q, err_q;
    logic [CNTW-1:0] cnt0_q, cnt1_q;

    always_ff @(posedge clk) begin
        if (rst) sync_q <= '0;
        else     sync_q <= SW'({sync_q, bus.actl_i});
    end

    assign ack_s = sync_q[SW-1];

    // Requester 1 wins when alone, or under round-robin when requester 0
    // was the last winner.
    assign sel1 = bus.req1 && (!bus.req0 || (PRIO == 0 && !last_q));

    // Watchdog value for "this cycle is also spent in SET/CLR"; saturates.
    assign wd_inc = (wd_q == 16'hFFFF) ? wd_q : wd_q + 16'd1;
    assign wd_hit = (TMO_L != 16'd0) && (wd_inc >= TMO_L);

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            gnt0_q  <= 1'b0;
            gnt1_q  <= 1'b0;
            done0_q <= 1'b0;
            done1_q <= 1'b0;
            ctl_a_q <= 1'b0;
            ctl_b_q <= 1'b0;
            cnt0_q  <= '0;
            cnt1_q  <= '0;
            last_q  <= 1'b1;
            wd_q    <= '0;
            err_q   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    // A new token may only start once the mux has returned
                    // to zero, keeping the handshake strictly four-phase.
                    if ((bus.req0 || bus.req1) && !ack_s) begin
                        state   <= SET;
                        gnt0_q  <= !sel1;
                        gnt1_q  <= sel1;
                        ctl_a_q <= !sel1;
                        ctl_b_q <= sel1;
                        last_q  <= sel1;
                        wd_q    <= 16'd1;
                        if (TMO_L == 16'd1) err_q <= 1'b1;
                    end
                end
                SET: begin
                    wd_q <= wd_inc;
                    if (wd_hit) err_q <= 1'b1;
                    if (ack_s) begin
                        ctl_a_q <= 1'b0;
                        ctl_b_q <= 1'b0;
                        state   <= CLR;
                    end
                end
                CLR: begin
                    if (!ack_s) begin
                        state   <= DONE;
                        done0_q <= gnt0_q;
                        done1_q <= gnt1_q;
                        wd_q    <= '0;
                        if (gnt0_q) cnt0_q <= cnt0_q + CNTW'(1);
                        if (gnt1_q) cnt1_q <= cnt1_q + CNTW'(1);
                    end else begin
                        wd_q <= wd_inc;
                        if (wd_hit) err_q <= 1'b1;
                    end
                end
                DONE: begin
                    state   <= IDLE;
                    gnt0_q  <= 1'b0;
                    gnt1_q  <= 1'b0;
                    done0_q <= 1'b0;
                    done1_q <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.gnt0  = gnt0_q;
    assign bus.gnt1  = gnt1_q;
    assign bus.done0 = done0_q;
    assign bus.done1 = done1_q;
    assign bus.ctl_a = ctl_a_q;
    assign bus.ctl_b = ctl_b_q;
    assign bus.cnt0  = cnt0_q;
    assign bus.cnt1  = cnt1_q;
    assign bus.busy  = (state != IDLE);
    assign bus.err   = err_q;
endmodule

// File: tb/tb_mux_sched.sv
// tb_mux_sched: two schedulers (A: round-robin, SYNC=2; B: fixed priority,
// SYNC=3; both CNTW=2, TMO=20) driven by directed and random requests.
// Each mux acknowledge follows its own ctl rails either combinationally or
// one cycle late, or can be held at 0. A transaction-level reference
// (phase + owner + ack delay line per instance) predicts every output.
module tb_mux_sched;
    localparam int SYA = 2;
    localparam int SYB = 3;
    localparam int TMO_V = 20;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mux_sched_if #(.CNTW(2)) ifa ();
    mux_sched_if #(.CNTW(2)) ifb ();

    mux_sched #(.SYNC(SYA), .PRIO(0), .TMO(TMO_V), .CNTW(2)) u_a (.clk(clk), .rst(rst), .bus(ifa.slave));
    mux_sched #(.SYNC(SYB), .PRIO(1), .TMO(TMO_V), .CNTW(2)) u_b (.clk(clk), .rst(rst), .bus(ifb.slave));

    // mux acknowledge models
    bit   ack_dly, ack_stuck;
    logic ca_q, cb_q;
    always @(posedge clk) begin
        ca_q <= ifa.ctl_a | ifa.ctl_b;
        cb_q <= ifb.ctl_a | ifb.ctl_b;
    end
    assign ifa.actl_i = !ack_stuck && (ack_dly ? ca_q : (ifa.ctl_a | ifa.ctl_b));
    assign ifb.actl_i = !ack_stuck && (ack_dly ? cb_q : (ifb.ctl_a | ifb.ctl_b));

    int checks = 0;
    int errors = 0;

    // reference: ph 0 free, 1 token up, 2 token returning, 3 completion
    int       ph   [2];
    int       hs   [2];
    bit       own  [2];
    bit       last [2];
    bit       merr [2];
    bit [1:0] mc   [2][2];
    bit       dl   [2][4];

    function automatic int sy(int i);
        return (i == 0) ? SYA : SYB;
    endfunction

    function automatic bit rq(int i, int j);
        if (i == 0) return (j == 0) ? ifa.req0 : ifa.req1;
        return (j == 0) ? ifb.req0 : ifb.req1;
    endfunction

    function automatic bit act(int i);
        return (i == 0) ? ifa.actl_i : ifb.actl_i;
    endfunction

    task automatic set_req(int i, int j, logic v);
        if (i == 0) begin
            if (j == 0) ifa.req0 = v; else ifa.req1 = v;
        end else begin
            if (j == 0) ifb.req0 = v; else ifb.req1 = v;
        end
    endtask

    // {gnt0,gnt1,ctl_a,ctl_b,done0,done1,busy,err,cnt0,cnt1}
    function automatic logic [11:0] obs(int i);
        if (i == 0) return {ifa.gnt0, ifa.gnt1, ifa.ctl_a, ifa.ctl_b, ifa.done0, ifa.done1,
                            ifa.busy, ifa.err, ifa.cnt0, ifa.cnt1};
        return {ifb.gnt0, ifb.gnt1, ifb.ctl_a, ifb.ctl_b, ifb.done0, ifb.done1,
                ifb.busy, ifb.err, ifb.cnt0, ifb.cnt1};
    endfunction

    function automatic logic [11:0] expv(int i);
        return {ph[i] != 0 && !own[i], ph[i] != 0 && own[i],
                ph[i] == 1 && !own[i], ph[i] == 1 && own[i],
                ph[i] == 3 && !own[i], ph[i] == 3 && own[i],
                ph[i] != 0, merr[i], mc[i][0], mc[i][1]};
    endfunction

    // advance one clock: update the reference from pre-edge inputs, then
    // return at the falling edge where outputs are sampled and inputs driven
    task automatic cyc();
        @(posedge clk);
        for (int i = 0; i < 2; i++) begin
            bit seen, r0, r1;
            seen = dl[i][sy(i) - 2];
            r0   = rq(i, 0);
            r1   = rq(i, 1);
            if (rst) begin
                ph[i] = 0; hs[i] = 0; last[i] = 1'b1; merr[i] = 1'b0;
                mc[i][0] = 2'd0; mc[i][1] = 2'd0;
            end else begin
                case (ph[i])
                    0: if ((r0 || r1) && !seen) begin
                        own[i]  = (r0 && r1) ? ((i == 1) ? 1'b0 : !last[i]) : r1;
                        last[i] = own[i];
                        ph[i]   = 1;
                        hs[i]   = 1;
                        if (TMO_V == 1) merr[i] = 1'b1;
                    end
                    1: begin
                        hs[i]++;
                        if (TMO_V != 0 && hs[i] >= TMO_V) merr[i] = 1'b1;
                        if (seen) ph[i] = 2;
                    end
                    2: if (!seen) begin
                        ph[i] = 3;
                        hs[i] = 0;
                        mc[i][own[i]]++;
                    end else begin
                        hs[i]++;
                        if (TMO_V != 0 && hs[i] >= TMO_V) merr[i] = 1'b1;
                    end
                    default: ph[i] = 0;
                endcase
            end
            for (int j = 3; j > 0; j--) dl[i][j] = rst ? 1'b0 : dl[i][j-1];
            dl[i][0] = rst ? 1'b0 : act(i);
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        ifa.req0 = 1'b0; ifa.req1 = 1'b0; ifb.req0 = 1'b0; ifb.req1 = 1'b0;
        ack_dly = 1'b0; ack_stuck = 1'b0;
        repeat (3) cyc();
        if ({obs(0), obs(1)} !== 24'h0) begin
            errors++; $display("FAIL reset_outputs got=%h want=000000", {obs(0), obs(1)});
        end
        checks++;
        rst = 1'b0;
        cyc();
        if ({obs(0), obs(1)} !== {expv(0), expv(1)}) begin
            errors++; $display("FAIL reset_idle got=%h want=%h", {obs(0), obs(1)}, {expv(0), expv(1)});
        end
        checks++;
    endtask

    task automatic test_single();
        int hi = 0, bhi = 0, dn = 0;
        bit got = 0;
        ack_dly = 1'b1;
        ifa.req0 = 1'b1;
        for (int c = 0; c < 40 && !got; c++) begin
            cyc();
            if ({obs(0), obs(1)} !== {expv(0), expv(1)}) begin
                errors++; $display("FAIL single_model t=%0t got=%h want=%h", $time, {obs(0), obs(1)}, {expv(0), expv(1)});
            end
            checks++;
            hi  += int'(ifa.ctl_a);
            bhi += int'(ifa.ctl_b);
            if (ifa.done0) begin dn++; got = 1; ifa.req0 = 1'b0; end
        end
        repeat (8) begin
            cyc();
            hi  += int'(ifa.ctl_a);
            bhi += int'(ifa.ctl_b);
            dn  += int'(ifa.done0);
        end
        if (!got) begin errors++; $display("FAIL single_timeout got=no_done want=done0"); end
        checks++;
        if (hi != SYA + 1) begin errors++; $display("FAIL single_ctl_a_high got=%0d want=%0d", hi, SYA + 1); end
        checks++;
        if (bhi != 0) begin errors++; $display("FAIL single_ctl_b got=%0d want=0", bhi); end
        checks++;
        if (dn != 1) begin errors++; $display("FAIL single_done_pulses got=%0d want=1", dn); end
        checks++;
        if (ifa.cnt0 !== 2'd1) begin errors++; $display("FAIL single_cnt0 got=%0d want=1", ifa.cnt0); end
        checks++;
    endtask

    task automatic test_rr_contention();
        int order[$];
        int tr[$];
        int nd = 0;
        bit pg0 = 0, pg1 = 0;
        rst = 1'b1; cyc(); rst = 1'b0;
        ack_dly = 1'b0;
        ifa.req0 = 1'b1; ifa.req1 = 1'b1;
        for (int c = 0; c < 100 && nd < 4; c++) begin
            cyc();
            if ({obs(0), obs(1)} !== {expv(0), expv(1)}) begin
                errors++; $display("FAIL rr_model t=%0t got=%h want=%h", $time, {obs(0), obs(1)}, {expv(0), expv(1)});
            end
            checks++;
            if (ifa.gnt0 && !pg0) begin order.push_back(0); tr.push_back(c); end
            if (ifa.gnt1 && !pg1) begin order.push_back(1); tr.push_back(c); end
            pg0 = ifa.gnt0; pg1 = ifa.gnt1;
            if (ifa.done0 || ifa.done1) nd++;
            if (nd == 4) begin ifa.req0 = 1'b0; ifa.req1 = 1'b0; end
        end
        if (nd != 4 || order.size() != 4) begin
            errors++; $display("FAIL rr_grants got=%0d want=4", order.size());
        end else begin
            for (int k = 0; k < 4; k++) begin
                if (order[k] != (k % 2)) begin errors++; $display("FAIL rr_order[%0d] got=%0d want=%0d", k, order[k], k % 2); end
                checks++;
                if (k > 0 && tr[k] - tr[k-1] != 2 * SYA + 2) begin
                    errors++; $display("FAIL rr_spacing[%0d] got=%0d want=%0d", k, tr[k] - tr[k-1], 2 * SYA + 2);
                end
                if (k > 0) checks++;
            end
        end
        checks++;
        if (ifa.cnt0 !== 2'd2 || ifa.cnt1 !== 2'd2) begin
            errors++; $display("FAIL rr_counts got=%0d/%0d want=2/2", ifa.cnt0, ifa.cnt1);
        end
        checks++;
    endtask

    task automatic test_prio();
        int n0 = 0, t0a = -1, t0b = -1;
        bit bad1 = 0, got1 = 0, pg0 = 0;
        ack_dly = 1'b0;
        ifb.req0 = 1'b1; ifb.req1 = 1'b1;
        for (int c = 0; c < 200 && !got1; c++) begin
            cyc();
            if ({obs(0), obs(1)} !== {expv(0), expv(1)}) begin
                errors++; $display("FAIL prio_model t=%0t got=%h want=%h", $time, {obs(0), obs(1)}, {expv(0), expv(1)});
            end
            checks++;
            if (ifb.gnt0 && !pg0) begin if (t0a < 0) t0a = c; else if (t0b < 0) t0b = c; end
            pg0 = ifb.gnt0;
            if (ifb.gnt1 && n0 < 3) bad1 = 1;
            if (ifb.done0) begin n0++; if (n0 == 3) ifb.req0 = 1'b0; end
            if (ifb.done1) begin got1 = 1; ifb.req1 = 1'b0; end
        end
        cyc();
        if (n0 != 3 || bad1) begin errors++; $display("FAIL prio_req0_only got=%0d bad1=%0d want=3 bad1=0", n0, bad1); end
        checks++;
        if (!got1) begin errors++; $display("FAIL prio_req1_after_drop got=no_done1 want=done1"); end
        checks++;
        if (t0b - t0a != 2 * SYB + 2) begin errors++; $display("FAIL prio_spacing got=%0d want=%0d", t0b - t0a, 2 * SYB + 2); end
        checks++;
        if (ifb.cnt0 !== 2'd3 || ifb.cnt1 !== 2'd1) begin
            errors++; $display("FAIL prio_counts got=%0d/%0d want=3/1", ifb.cnt0, ifb.cnt1);
        end
        checks++;
    endtask

    task automatic test_wrap();
        int nd = 0;
        rst = 1'b1; cyc(); rst = 1'b0;
        ifa.req0 = 1'b1;
        for (int c = 0; c < 200 && nd < 5; c++) begin
            cyc();
            if ({obs(0), obs(1)} !== {expv(0), expv(1)}) begin
                errors++; $display("FAIL wrap_model t=%0t got=%h want=%h", $time, {obs(0), obs(1)}, {expv(0), expv(1)});
            end
            checks++;
            if (ifa.done0) begin
                logic [1:0] want;
                want = 2'((nd + 1) % 4);
                if (ifa.cnt0 !== want) begin errors++; $display("FAIL wrap_cnt0[%0d] got=%0d want=%0d", nd, ifa.cnt0, want); end
                checks++;
                nd++;
                ack_dly = 1'($urandom_range(0, 1));
                if (nd == 5) ifa.req0 = 1'b0;
            end
        end
        if (nd != 5) begin errors++; $display("FAIL wrap_grants got=%0d want=5", nd); end
        checks++;
        ack_dly = 1'b0;
        repeat (3) cyc();
    endtask

    task automatic test_watchdog();
        int ns = 0;
        bit got = 0;
        rst = 1'b1; cyc(); rst = 1'b0;
        ack_stuck = 1'b1;
        ifa.req1 = 1'b1;
        for (int c = 0; c < 30; c++) begin
            cyc();
            if ({obs(0), obs(1)} !== {expv(0), expv(1)}) begin
                errors++; $display("FAIL wd_model t=%0t got=%h want=%h", $time, {obs(0), obs(1)}, {expv(0), expv(1)});
            end
            checks++;
            if (ifa.ctl_b) ns++;
            if (ifa.ctl_b && ns == TMO_V - 1) begin
                if (ifa.err !== 1'b0) begin errors++; $display("FAIL wd_early got=%b want=0", ifa.err); end
                checks++;
            end
            if (ifa.ctl_b && ns == TMO_V) begin
                if (ifa.err !== 1'b1) begin errors++; $display("FAIL wd_fire got=%b want=1", ifa.err); end
                checks++;
            end
        end
        if ({ifa.ctl_b, ifa.gnt1, ifa.busy, ifa.err} !== 4'b1111) begin
            errors++; $display("FAIL wd_still_set got=%b want=1111", {ifa.ctl_b, ifa.gnt1, ifa.busy, ifa.err});
        end
        checks++;
        ack_stuck = 1'b0;
        for (int c = 0; c < 20 && !got; c++) begin
            cyc();
            if (ifa.done1) begin got = 1; ifa.req1 = 1'b0; end
        end
        cyc();
        if (!got || ifa.err !== 1'b1 || ifa.cnt1 !== 2'd1) begin
            errors++; $display("FAIL wd_release got=done%0d err%b cnt1=%0d want=done1 err1 cnt1=1", got, ifa.err, ifa.cnt1);
        end
        checks++;
    endtask

    task automatic test_rst_mid();
        bit in_clr = 0, got = 0;
        ifa.req0 = 1'b1;
        for (int c = 0; c < 20 && !in_clr; c++) begin
            cyc();
            in_clr = ifa.gnt0 && !ifa.ctl_a && !ifa.done0;
        end
        if (!in_clr) begin errors++; $display("FAIL rstmid_reach_clr got=0 want=1"); end
        checks++;
        rst = 1'b1; ifa.req0 = 1'b0;
        cyc();
        if (obs(0) !== 12'h0) begin errors++; $display("FAIL rstmid_outputs got=%h want=000", obs(0)); end
        checks++;
        rst = 1'b0;
        ifa.req1 = 1'b1;
        for (int c = 0; c < 20 && !got; c++) begin
            cyc();
            if ({obs(0), obs(1)} !== {expv(0), expv(1)}) begin
                errors++; $display("FAIL rstmid_model t=%0t got=%h want=%h", $time, {obs(0), obs(1)}, {expv(0), expv(1)});
            end
            checks++;
            if (ifa.done1) begin got = 1; ifa.req1 = 1'b0; end
        end
        if (!got || ifa.cnt1 !== 2'd1 || ifa.cnt0 !== 2'd0) begin
            errors++; $display("FAIL rstmid_regrant got=done%0d cnt=%0d/%0d want=done1 cnt=0/1", got, ifa.cnt0, ifa.cnt1);
        end
        checks++;
    endtask

    task automatic test_random();
        ack_dly = 1'($urandom_range(0, 1));
        for (int c = 0; c < 500; c++) begin
            cyc();
            if ({obs(0), obs(1)} !== {expv(0), expv(1)}) begin
                errors++; $display("FAIL rand_model t=%0t got=%h want=%h", $time, {obs(0), obs(1)}, {expv(0), expv(1)});
            end
            checks++;
            for (int i = 0; i < 2; i++) begin
                logic [11:0] o;
                o = obs(i);
                if ((o[11] && o[10]) || (o[9] && o[8])) begin
                    errors++; $display("FAIL rand_exclusive inst=%0d got=%h want=one_hot", i, o);
                end
                checks++;
                for (int j = 0; j < 2; j++) begin
                    if (o[7-j]) set_req(i, j, 1'b0);
                    else if (!rq(i, j)) begin
                        if ($urandom_range(0, 3) == 0) set_req(i, j, 1'b1);
                    end else if (!o[11-j]) begin
                        if ($urandom_range(0, 15) == 0) set_req(i, j, 1'b0);
                    end else if ($urandom_range(0, 31) == 0) set_req(i, j, 1'b0);
                end
            end
            if (c == 250) ack_dly = !ack_dly && (ph[0] == 0) && (ph[1] == 0) ? 1'b1 : ack_dly;
        end
        for (int i = 0; i < 2; i++) for (int j = 0; j < 2; j++) set_req(i, j, 1'b0);
        repeat (12) cyc();
    endtask

    initial begin
        #300000;
        $display("FAIL global_timeout got=running want=finished");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            ph[i] = 0; hs[i] = 0; own[i] = 0; last[i] = 1; merr[i] = 0;
            mc[i][0] = 0; mc[i][1] = 0;
            for (int j = 0; j < 4; j++) dl[i][j] = 0;
        end
        test_reset();
        test_single();
        test_rr_contention();
        test_prio();
        test_wrap();
        test_watchdog();
        test_rst_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
